// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Words are queued through a valid/ready port and sent as
// start + data (LSB first) + optional parity + 1 or 2 stop bits.
// Back-to-back frames follow each other with no idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          tx_clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          uart_data,
    input  logic                          uart_data_valid,
    output logic                          uart_data_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head_word;
    logic                 head_parity;

    logic [2:0]           state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 stop_second;

    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 frame_end;

    // Ready depends only on the registered level, never on valid.
    assign uart_data_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push            = uart_data_valid && uart_data_ready;
    assign bit_done        = (div_cnt == DIV_W'(OVERSAMPLE - 1));
    assign frame_end       = (state == STOP) && bit_done && (!two_stop_q || stop_second);
    assign pop             = (fifo_level != '0) && ((state == IDLE) || frame_end);
    assign head_word       = mem[rd_ptr];

    // Parity of the word about to be popped, using the mode in force at the pop.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        head_parity = 1'b1;
        case (parity_mode)
            2'b01:   head_parity = ^head_word;
            2'b10:   head_parity = ~^head_word;
            default: head_parity = 1'b1;
        endcase
    end

    // FIFO storage: written on accept, contents are don't-care until the level says otherwise.
    always_ff @(posedge tx_clk) begin
        // NOTE: the storage array has no reset; the pointers and level define what is valid.
        if (reset_n && push) begin
            mem[wr_ptr] <= uart_data;
        end
    end

    // FIFO pointers and level; pointers wrap naturally, the level tells full from empty.
    always_ff @(posedge tx_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame sequencer: bit divider, shifter and the registered serial line.
    always_ff @(posedge tx_clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            uart_tx     <= 1'b1;
            tx_busy     <= 1'b0;
            div_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_second <= 1'b0;
        end else if (pop) begin
            // Start of a frame, either from idle or straight after a stop period.
            state       <= START;
            uart_tx     <= 1'b0;
            tx_busy     <= 1'b1;
            div_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= head_word;
            par_en_q    <= (parity_mode != 2'b00);
            par_bit_q   <= head_parity;
            two_stop_q  <= two_stop;
            stop_second <= 1'b0;
        end else if (state == IDLE) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            div_cnt <= '0;
        end else if (!bit_done) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            case (state)
                START: begin
                    state   <= DATA;
                    uart_tx <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        if (par_en_q) begin
                            state   <= PARITY;
                            uart_tx <= par_bit_q;
                        end else begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        uart_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    uart_tx <= 1'b1;
                end
                STOP: begin
                    if (two_stop_q && !stop_second) begin
                        stop_second <= 1'b1;
                    end else begin
                        // FIFO empty at the end of the frame (a pop would have won above).
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                        uart_tx <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// A queue-based frame model predicts line, busy, level and ready every cycle;
// directed scenarios add hand-computed literal expectations.
module tb_uart_tx_fifo;

    logic       tx_clk = 1'b0;
    logic       reset_n;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic       uart_data_ready;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       uart_tx;
    logic       tx_busy;
    logic [3:0] fifo_level;

    logic [4:0] uart_data5;
    logic       uart_data_valid5;
    logic       uart_data_ready5;
    logic       uart_tx5;
    logic       tx_busy5;
    logic [3:0] fifo_level5;

    int checks   = 0;
    int failures = 0;

    always #5 tx_clk = ~tx_clk;

    uart_tx_fifo dut (
        .tx_clk          (tx_clk),
        .reset_n         (reset_n),
        .uart_data       (uart_data),
        .uart_data_valid (uart_data_valid),
        .uart_data_ready (uart_data_ready),
        .parity_mode     (parity_mode),
        .two_stop        (two_stop),
        .uart_tx         (uart_tx),
        .tx_busy         (tx_busy),
        .fifo_level      (fifo_level)
    );

    uart_tx_fifo #(.DATA_BITS(5), .OVERSAMPLE(4), .FIFO_DEPTH(8)) dut5 (
        .tx_clk          (tx_clk),
        .reset_n         (reset_n),
        .uart_data       (uart_data5),
        .uart_data_valid (uart_data_valid5),
        .uart_data_ready (uart_data_ready5),
        .parity_mode     (parity_mode),
        .two_stop        (two_stop),
        .uart_tx         (uart_tx5),
        .tx_busy         (tx_busy5),
        .fifo_level      (fifo_level5)
    );

    // Model of the default instance: a word queue plus the bit list of the frame on the line.
    logic [7:0] m_q[$];
    logic       m_bits [0:12];
    logic       m_busy    = 1'b0;
    int         m_len     = 0;
    int         m_cyc     = 0;
    int         m_accepts = 0;

    logic       tr_tx   [0:399];
    logic       tr_busy [0:399];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_start(input logic [7:0] w);
        int n;
        n = 0;
        m_bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            m_bits[n] = w[i];
            n++;
        end
        if (parity_mode != 2'b00) begin
            if (parity_mode == 2'b01)      m_bits[n] = ^w;
            else if (parity_mode == 2'b10) m_bits[n] = ~^w;
            else                           m_bits[n] = 1'b1;
            n++;
        end
        m_bits[n] = 1'b1;
        n++;
        if (two_stop) begin
            m_bits[n] = 1'b1;
            n++;
        end
        m_len  = n;
        m_cyc  = 0;
        m_busy = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic m_edge();
        logic acc;
        if (!reset_n) begin
            m_q.delete();
            m_busy = 1'b0;
        end else begin
            acc = uart_data_valid && (m_q.size() < 8);
            if (m_busy) begin
                m_cyc++;
                if (m_cyc == m_len * 16) m_busy = 1'b0;
            end
            if (!m_busy && m_q.size() > 0) m_start(m_q.pop_front());
            if (acc) begin
                m_q.push_back(uart_data);
                m_accepts++;
            end
        end
    endtask

    task automatic compare();
        logic exp_tx;
        exp_tx = m_busy ? m_bits[m_cyc / 16] : 1'b1;
        check("uart_tx", 32'(uart_tx), 32'(exp_tx));
        check("tx_busy", 32'(tx_busy), 32'(m_busy));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("uart_data_ready", 32'(uart_data_ready), 32'(m_q.size() != 8));
    endtask

    task automatic step();
        @(posedge tx_clk);
        m_edge();
        #1;
        compare();
    endtask

    task automatic capture(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            tr_tx[first + i]   = uart_tx;
            tr_busy[first + i] = tx_busy;
        end
    endtask

    task automatic write_word(input logic [7:0] w);
        uart_data       = w;
        uart_data_valid = 1'b1;
        step();
        uart_data_valid = 1'b0;
    endtask

    function automatic int busy_count(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (tr_busy[i]) c++;
        return c;
    endfunction

    function automatic int high_count(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (tr_tx[i]) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_a;
        logic [3:1] exp_par;
        int         acc0;
        int         lows;

        reset_n          = 1'b0;
        uart_data        = 8'h00;
        uart_data_valid  = 1'b0;
        uart_data5       = 5'h00;
        uart_data_valid5 = 1'b0;
        parity_mode      = 2'b00;
        two_stop         = 1'b0;
        step();
        step();
        check("reset uart_tx", 32'(uart_tx), 32'd1);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset ready", 32'(uart_data_ready), 32'd1);
        reset_n = 1'b1;
        step();

        // 8N1 frame of 0x55.
        write_word(8'h55);
        capture(0, 200);
        exp_a = 10'b1010101010;
        check("55 busy cycles", 32'(busy_count(0, 199)), 32'd160);
        check("55 start low", 32'(high_count(0, 15)), 32'd0);
        check("55 bit0 edge", 32'(tr_tx[16]), 32'd1);
        for (int k = 0; k < 10; k++) check("55 bit sample", 32'(tr_tx[16 * k + 8]), 32'(exp_a[k]));
        check("55 idle after", 32'(high_count(160, 199)), 32'd40);

        // Parity modes on 0x07; mode is changed mid-frame and must not matter.
        exp_par = 3'b101;
        for (int mode = 1; mode <= 3; mode++) begin
            parity_mode = 2'(mode);
            write_word(8'h07);
            capture(0, 40);
            parity_mode = 2'(mode) ^ 2'b11;
            capture(40, 160);
            check("parity bit", 32'(tr_tx[152]), 32'(exp_par[mode]));
            check("parity frame cycles", 32'(busy_count(0, 199)), 32'd176);
        end

        // Two stop bits, two words back to back.
        parity_mode     = 2'b00;
        two_stop        = 1'b1;
        uart_data       = 8'hA3;
        uart_data_valid = 1'b1;
        step();
        uart_data = 8'h3C;
        capture(0, 1);
        uart_data_valid = 1'b0;
        capture(1, 399);
        check("2stop total busy", 32'(busy_count(0, 399)), 32'd352);
        check("2stop stop high", 32'(high_count(144, 175)), 32'd32);
        check("2stop second start", 32'(tr_tx[176]), 32'd0);
        check("2stop no gap", 32'(tr_busy[176]), 32'd1);
        check("2stop A3 bit7", 32'(tr_tx[136]), 32'd1);
        check("2stop 3C bit2", 32'(tr_tx[176 + 16 * 3 + 8]), 32'd1);
        check("2stop idle after", 32'(tr_busy[352]), 32'd0);
        two_stop = 1'b0;

        // Fill the FIFO: valid held for 12 cycles from idle.
        acc0            = m_accepts;
        uart_data_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            uart_data = 8'(8'h10 + i);
            step();
        end
        uart_data_valid = 1'b0;
        check("fill accepted", 32'(m_accepts - acc0), 32'd9);
        check("fill level", 32'(fifo_level), 32'd8);
        check("fill ready low", 32'(uart_data_ready), 32'd0);
        for (int i = 0; i < 149; i++) step();
        check("fill ready before pop", 32'(uart_data_ready), 32'd0);
        step();
        check("fill ready after pop", 32'(uart_data_ready), 32'd1);
        check("fill level after pop", 32'(fifo_level), 32'd7);
        for (int i = 0; i < 1300; i++) step();
        check("fill drained busy", 32'(tx_busy), 32'd0);

        // Reset in the middle of a frame with five words queued, write offered too.
        uart_data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            uart_data = 8'(8'h60 + i);
            step();
        end
        uart_data_valid = 1'b0;
        check("abort queued", 32'(fifo_level), 32'd5);
        for (int i = 0; i < 65; i++) step();
        reset_n         = 1'b0;
        uart_data_valid = 1'b1;
        uart_data       = 8'hEE;
        step();
        check("abort uart_tx", 32'(uart_tx), 32'd1);
        check("abort fifo_level", 32'(fifo_level), 32'd0);
        check("abort tx_busy", 32'(tx_busy), 32'd0);
        check("abort ready", 32'(uart_data_ready), 32'd1);
        reset_n         = 1'b1;
        uart_data_valid = 1'b0;
        lows            = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!uart_tx) lows++;
        end
        check("abort no restart", 32'(lows), 32'd0);

        // Small instance: 5 data bits, 4x oversampling, even parity on 0x1F.
        parity_mode      = 2'b01;
        uart_data5       = 5'h1F;
        uart_data_valid5 = 1'b1;
        step();
        uart_data_valid5 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            check("dut5 uart_tx", 32'(uart_tx5), (c < 4) ? 32'd0 : 32'd1);
            check("dut5 tx_busy", 32'(tx_busy5), (c < 32) ? 32'd1 : 32'd0);
        end
        check("dut5 fifo_level", 32'(fifo_level5), 32'd0);
        parity_mode = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning tx_clk cycles per bit period (legal 4..256).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of 2, 2..256).
REQ-004 SHALL have port tx_clk, input, 1, the single clock, OVERSAMPLE x baud rate.
REQ-005 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port uart_data, input, DATA_BITS, the word to send, LSB first.
REQ-007 SHALL have port uart_data_valid, input, 1, meaning uart_data is offered this cycle.
REQ-008 SHALL have port uart_data_ready, output, 1, meaning the FIFO accepts a word this cycle.
REQ-009 SHALL have port parity_mode, input, 2, with values 00 none, 01 even, 10 odd, 11 mark (constant 1).
REQ-010 SHALL have port two_stop, input, 1, meaning 1 selects two stop bits and 0 selects one.
REQ-011 SHALL have port uart_tx, output, 1, the registered serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1, meaning a frame is in progress.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, the number of words held in the FIFO.

Function
REQ-014 SHALL accept a word on a rising tx_clk edge when uart_data_valid and uart_data_ready are both high.
REQ-015 SHALL drive uart_data_ready as !(fifo_level == FIFO_DEPTH), with no combinational path from uart_data_valid.
REQ-016 SHALL ignore uart_data_valid while uart_data_ready is low: no write, no error, level unchanged.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL go from IDLE to START on the first edge where the FIFO is non-empty; that edge pops the head word and latches parity_mode and two_stop.
REQ-019 SHALL drive uart_tx low on that same edge; the earliest start-bit fall is one edge after the accepting edge.
REQ-020 SHALL hold each bit for exactly OVERSAMPLE cycles, using a divider counter that restarts at each bit boundary.
REQ-021 SHALL step START -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if parity_mode != 00) -> STOP (1 or 2 bit periods, uart_tx high).
REQ-022 SHALL compute parity as: even = XOR of data bits; odd = inverted XOR; mark = 1; all over DATA_BITS bits only.
REQ-023 SHALL ignore changes to parity_mode and two_stop during a frame; they take effect at the next pop.
REQ-024 SHALL, at the end of the final stop period, go directly to START on the next edge (zero idle gap) if the FIFO is non-empty, otherwise go to IDLE with uart_tx high.
REQ-025 SHALL, on a simultaneous accept and pop, leave fifo_level unchanged and lose no data.
REQ-026 SHALL wrap the read and write pointers modulo FIFO_DEPTH and distinguish full from empty using the level count.
REQ-027 SHALL drive tx_busy high from the START edge until the edge that enters IDLE.
REQ-028 SHALL give a frame length of OVERSAMPLE*(1 + DATA_BITS + P + S) cycles, where P = (parity_mode != 00) and S = 1 + two_stop.

Reset
REQ-029 SHALL, on any edge with reset_n low, set: uart_tx=1, state IDLE, tx_busy=0, fifo_level=0, pointers=0, divider=0, uart_data_ready=1 on the following cycle.
REQ-030 SHALL, on reset mid-frame, abort the frame immediately, discard all FIFO contents and raise the line high with no truncated stop bit.
REQ-031 SHALL give reset priority over a simultaneous write.

Verification
REQ-032 SHALL cover: defaults, parity 00, one stop, write 0x55 -> uart_tx low 16 cycles, then bits 1,0,1,0,1,0,1,0 each 16 cycles, then high; tx_busy high 160 cycles.
REQ-033 SHALL cover: parity_mode=01, write 0x07 -> parity bit 1; parity_mode=10, write 0x07 -> parity bit 0; parity_mode=11 -> parity bit 1; frame 176 cycles.
REQ-034 SHALL cover: two_stop=1, write 0xA3 then 0x3C back-to-back -> line high exactly 32 cycles between frames, second start immediate, total 352 cycles.
REQ-035 SHALL cover: valid held high for 12 cycles from idle -> 9 words accepted (one popped), ready low while fifo_level==8, and ready returns high the cycle after the next pop.
REQ-036 SHALL cover: reset_n low at cycle 70 of a frame with 5 words queued -> uart_tx=1, fifo_level=0, tx_busy=0 after that edge, and no further start bits.
REQ-037 SHALL cover: DATA_BITS=5, OVERSAMPLE=4, write 0x1F with parity_mode=01 -> parity bit 1, frame 32 cycles.
